jk_bank_controller: RTL and testbench
=====================================

JK_BANK_CONTROLLER -- requirements
Module: jk_bank_controller

Interface
REQ-001 Parameter WIDTH, default 8, number of JK flip-flops in the controlled bank.
REQ-002 Parameter REP_W, default 4, width of the repeat-count field.
REQ-003 The block SHALL have port clk, input, 1, single clock; every register updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port cmd_valid, input, 1, command present.
REQ-006 The block SHALL have port cmd_ready, output, 1, controller can accept a command.
REQ-007 The block SHALL have port cmd_op, input, 2, operation: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-008 The block SHALL have port cmd_mask, input, WIDTH, selects the bank bits the operation acts on.
REQ-009 The block SHALL have port cmd_rep, input, REP_W, apply operation cmd_rep+1 consecutive cycles.
REQ-010 The block SHALL have port cmd_abort, input, 1, terminate the active command early.
REQ-011 The block SHALL have port j, output, WIDTH, J drive to the bank.
REQ-012 The block SHALL have port k, output, WIDTH, K drive to the bank.
REQ-013 The block SHALL have port busy, output, 1, command in progress.
REQ-014 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 The block SHALL have port aborted, output, 1, qualifies done: the command was aborted.
REQ-016 The block SHALL have port q_shadow, output, WIDTH, modelled bank state (see Configuration).

Function
REQ-017 The controller SHALL implement the FSM states IDLE, APPLY and DONE; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance the controller SHALL latch op, mask and rep, and SHALL enter APPLY with counter=rep and busy=1.
REQ-020 In APPLY, j/k SHALL be: hold j=0,k=0; clear j=0,k=mask; set j=mask,k=0; toggle j=mask,k=mask; unmasked bits SHALL always be 0.
REQ-021 j/k SHALL first be driven in the cycle after acceptance and SHALL be held for exactly rep+1 cycles (rep=0 gives 1 cycle; rep=15 gives 16 cycles).
REQ-022 The counter SHALL decrement once per APPLY cycle; in the APPLY cycle with counter=0 the next state SHALL be DONE.
REQ-023 In DONE, j=k=0, busy=0 and done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-024 cmd_abort=1 sampled in APPLY SHALL force DONE on the next edge with aborted=1; in that DONE cycle, j=k=0.
REQ-025 aborted SHALL be 1 only together with done.
REQ-026 cmd_abort SHALL be ignored in IDLE and DONE; abort and cmd_valid asserted together in IDLE SHALL accept the command normally.
REQ-027 cmd_valid in APPLY or DONE SHALL NOT be accepted; the requester holds the command until cmd_ready=1.
REQ-028 The earliest back-to-back acceptance SHALL be the edge after DONE, giving a minimum command spacing of rep+3 cycles.

Reset
REQ-029 When rst=0 at a rising edge, the next state SHALL be IDLE regardless of current state, including mid-APPLY.
REQ-030 Reset values SHALL be: j=0, k=0, busy=0, done=0, aborted=0, counter=0, q_shadow=0, cmd_ready=1.
REQ-031 The first command SHALL be accepted no earlier than the first edge with rst=1.

Configuration
REQ-032 The shadow model SHALL be compiled in only when macro JK_BANK_SHADOW_EN is defined.
REQ-033 With JK_BANK_SHADOW_EN defined, on every edge q_shadow bits SHALL update by JK rules from the current j/k outputs (00 keep, 01 clear, 10 set, 11 invert), tracking a bank reset by the same rst.
REQ-034 Without JK_BANK_SHADOW_EN, q_shadow SHALL be constant 0 and the shadow register logic SHALL be absent.

Verification
REQ-035 Reset, then set with mask=8'hA5, rep=0 -> j=A5, k=00 for 1 cycle, then done=1, aborted=0; q_shadow=A5 (shadow enabled).
REQ-036 After REQ-035, toggle with mask=8'hFF, rep=2 -> j=k=FF for 3 cycles, busy=1 for 3 cycles; q_shadow: A5 -> 5A -> A5 -> 5A.
REQ-037 Clear with mask=8'h0F, rep=15, cmd_abort=1 in the 4th APPLY cycle -> exactly 4 active cycles, then done=1 and aborted=1 together.
REQ-038 Command held valid during APPLY -> not accepted until the edge after DONE; cmd_ready=0 throughout busy and done.
REQ-039 rst=0 during the 2nd cycle of a rep=5 toggle -> next cycle j=k=0, busy=0, cmd_ready=1, q_shadow=0, no done pulse.
REQ-040 Build without JK_BANK_SHADOW_EN and rerun REQ-035 -> identical j/k/done timing, q_shadow=0.

Source files
------------

// File: rtl/jk_bank_controller.sv
// JK bank controller: applies hold/clear/set/toggle to a masked JK flip-flop bank
// for cmd_rep+1 cycles, with early abort and a one-cycle done pulse.
// Optional macro JK_BANK_SHADOW_EN compiles in a shadow model of the bank state.
module jk_bank_controller #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             cmd_abort,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] q_shadow
);

  typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             ready_q, ready_d;

  // Next-state and registered-output computation; j/k are zero unless staying in APPLY.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    j_d       = '0;
    k_d       = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    ready_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          state_d = StApply;
          op_d    = cmd_op;
          mask_d  = cmd_mask;
          cnt_d   = cmd_rep;
          j_d     = cmd_op[1] ? cmd_mask : '0;
          k_d     = cmd_op[0] ? cmd_mask : '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      StApply: begin
        if (cmd_abort) begin
          state_d   = StDone;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          j_d    = op_q[1] ? mask_q : '0;
          k_d    = op_q[0] ? mask_q : '0;
          busy_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      mask_q    <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

`ifdef JK_BANK_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;

  // Shadow bank follows JK rules from the driven j/k: keep, clear, set, invert.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= (j_q & ~shadow_q) | (~k_q & shadow_q);
    end
  end

  assign q_shadow = shadow_q;
`else
  assign q_shadow = '0;
`endif

endmodule

// File: tb/tb_jk_bank_controller.sv
// Self-checking bench for jk_bank_controller: directed scenarios plus randomized
// commands checked against a cycle-level reference model of the command protocol.
module tb_jk_bank_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_mask;
  logic [3:0] cmd_rep;
  logic       cmd_abort;
  logic [7:0] j, k, q_shadow;
  logic       busy, done, aborted;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_sh;

  jk_bank_controller #(.WIDTH(8), .REP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_rep   (cmd_rep),
    .cmd_abort (cmd_abort),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .q_shadow  (q_shadow)
  );

  always #5 clk = ~clk;

  // Bank-level effect of one active cycle of an operation.
  function automatic logic [7:0] apply_op(input logic [7:0] s, input logic [1:0] op,
                                          input logic [7:0] m);
    case (op)
      2'b00:   return s;
      2'b01:   return s & ~m;
      2'b10:   return s | m;
      default: return s ^ m;
    endcase
  endfunction

  function automatic logic [7:0] exp_j(input logic [1:0] op, input logic [7:0] m);
    return (op == 2'b10 || op == 2'b11) ? m : 8'h00;
  endfunction

  function automatic logic [7:0] exp_k(input logic [1:0] op, input logic [7:0] m);
    return (op == 2'b01 || op == 2'b11) ? m : 8'h00;
  endfunction

  function automatic logic [7:0] shadow_exp();
`ifdef JK_BANK_SHADOW_EN
    return model_sh;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [27:0] obs();
    return {j, k, busy, done, aborted, cmd_ready, q_shadow};
  endfunction

  function automatic logic [27:0] expv(input logic [7:0] ej, input logic [7:0] ek,
                                       input logic b, input logic d, input logic a,
                                       input logic r);
    return {ej, ek, b, d, a, r, shadow_exp()};
  endfunction

  // One full command from IDLE back to IDLE; abort_at>0 raises abort in that APPLY cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] rep,
                         input int abort_at, input logic idle_abort);
    int n;
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL cmd_idle_pre: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_rep = rep; cmd_abort = idle_abort;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_abort = 1'b0;
    cmd_op = 2'($urandom); cmd_mask = 8'($urandom); cmd_rep = 4'($urandom);
    n = (abort_at > 0) ? abort_at : int'(rep) + 1;
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs() !== expv(exp_j(op, mask), exp_k(op, mask), 1'b1, 1'b0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL apply_cycle%0d: got %h expected %h", c, obs(),
                 expv(exp_j(op, mask), exp_k(op, mask), 1'b1, 1'b0, 1'b0, 1'b0));
      end
      if (c == abort_at) cmd_abort = 1'b1;
      @(negedge clk);
      model_sh = apply_op(model_sh, op, mask);
    end
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b1, abort_at > 0, 1'b0)) begin
      errors++;
      $display("FAIL done_cycle: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b1, abort_at > 0, 1'b0));
    end
    // Abort during DONE must be ignored.
    cmd_abort = 1'($urandom);
    @(negedge clk);
    cmd_abort = 1'b0;
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL idle_post: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'hFF; cmd_rep = 4'd0;
    cmd_abort = 1'b0;
    model_sh = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_set_single();
    run_cmd(2'b10, 8'hA5, 4'd0, 0, 1'b0);
    checks++;
    if (q_shadow !== shadow_exp()) begin
      errors++;
      $display("FAIL set_shadow: got %h expected %h", q_shadow, shadow_exp());
    end
  endtask

  task automatic test_toggle();
    run_cmd(2'b11, 8'hFF, 4'd2, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_cmd(2'b01, 8'h0F, 4'd15, 4, 1'b0);
    // Abort alongside valid in IDLE still accepts normally.
    run_cmd(2'b10, 8'h3C, 4'd1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_mask = 8'h3C; cmd_rep = 4'd1;
    @(negedge clk);
    cmd_op = 2'b10; cmd_mask = 8'h81; cmd_rep = 4'd0;
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (obs() !== expv(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL b2b_apply%0d: got %h expected %h", c, obs(),
                 expv(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      model_sh = apply_op(model_sh, 2'b11, 8'h3C);
    end
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL b2b_done: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (obs() !== expv(8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL b2b_second_accept: got %h expected %h", obs(),
               expv(8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    model_sh = apply_op(model_sh, 2'b10, 8'h81);
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL b2b_second_done: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_mask = 8'hFF; cmd_rep = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (obs() !== expv(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL rstmid_apply1: got %h expected %h", obs(),
               expv(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    model_sh = apply_op(model_sh, 2'b11, 8'hFF);
    rst = 1'b0;
    @(negedge clk);
    model_sh = 8'h00;
    rst = 1'b1;
    checks++;
    if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL rstmid_reset: got %h expected %h", obs(),
               expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
        errors++;
        $display("FAIL rstmid_no_done%0d: got %h expected %h", c, obs(),
                 expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] mask;
    logic [3:0] rep;
    int abort_at;
    int gap;
    for (int i = 0; i < 30; i++) begin
      op       = 2'($urandom_range(0, 3));
      mask     = 8'($urandom);
      rep      = 4'($urandom_range(0, 15));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rep) + 1)) : 0;
      run_cmd(op, mask, rep, abort_at, 1'($urandom));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        cmd_abort = 1'($urandom);
        @(negedge clk);
        cmd_abort = 1'b0;
        checks++;
        if (obs() !== expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)) begin
          errors++;
          $display("FAIL rand_idle%0d: got %h expected %h", i, obs(),
                   expv(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_set_single();
    test_toggle();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
